// File: rtl/dm_if.sv
// Data-memory access bundle: the datapath side drives address/write controls, the memory returns read data.
interface dm_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              memwrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;

    modport master (output memwrite, output addr, output wd, input rd);
    modport slave  (input memwrite, input addr, input wd, output rd);
endinterface

// File: rtl/dm.sv
// Word-organised data memory: combinational read, write on rising clk, whole array cleared by sync reset.
// Latency: rd follows addr/contents combinationally; writes visible right after the edge. No backpressure.
module dm #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic clk,
    input  logic rst,
    dm_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [IDX_W-1:0] idx;
    logic             in_range;

    // Byte-offset bits are dropped; any set bit above the index field marks the access out of range.
    assign idx      = bus.addr[IDX_W+1:2];
    assign in_range = ((bus.addr >> (IDX_W + 2)) == '0);

    always_comb begin
        mem_d = mem_q;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else if (bus.memwrite && in_range) begin
            mem_d[idx] = bus.wd;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.rd = in_range ? mem_q[idx] : '0;
endmodule

// File: tb/tb_dm.sv
module tb_dm;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dm_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    dm #(.DATA_W(32), .DEPTH(64), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Inputs change on the falling edge; outputs sampled 1 time unit later.
    task automatic drive(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst          = r;
        bus.memwrite = we;
        bus.addr     = a;
        bus.wd       = d;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [3];
        addrs = '{32'd0, 32'd4, 32'd252};
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if (bus.rd !== 32'd0) begin
            errors++;
            $display("FAIL powerup_addr0: rd=%h expected=%h", bus.rd, 32'd0);
        end
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, addrs[i], 32'd0);
            checks++;
            if (bus.rd !== 32'd0) begin
                errors++;
                $display("FAIL reset_read addr=%0d: rd=%h expected=%h", addrs[i], bus.rd, 32'd0);
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] addrs [3];
        logic [31:0] exp   [3];
        addrs = '{32'd8, 32'd4, 32'd12};
        exp   = '{32'hDEADBEEF, 32'd0, 32'd0};
        drive(1'b0, 1'b1, 32'd8, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, addrs[i], 32'h0);
            checks++;
            if (bus.rd !== exp[i]) begin
                errors++;
                $display("FAIL write_read addr=%0d: rd=%h expected=%h", addrs[i], bus.rd, exp[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        drive(1'b0, 1'b1, 32'd16, 32'h12345678);
        for (int a = 16; a < 20; a++) begin
            drive(1'b0, 1'b0, 32'(a), 32'h0);
            checks++;
            if (bus.rd !== 32'h12345678) begin
                errors++;
                $display("FAIL misaligned addr=%0d: rd=%h expected=%h", a, bus.rd, 32'h12345678);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [5];
        logic [31:0] exp   [5];
        addrs = '{32'd0, 32'd256, 32'd8, 32'd252, 32'h8000_0008};
        exp   = '{32'd0, 32'd0, 32'hDEADBEEF, 32'd0, 32'd0};
        drive(1'b0, 1'b1, 32'd256, 32'hFFFFFFFF);
        drive(1'b0, 1'b1, 32'h8000_0008, 32'hFFFFFFFF);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, addrs[i], 32'h0);
            checks++;
            if (bus.rd !== exp[i]) begin
                errors++;
                $display("FAIL out_of_range addr=%h: rd=%h expected=%h", addrs[i], bus.rd, exp[i]);
            end
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 1'b1, 32'd8, 32'h1);
        drive(1'b0, 1'b0, 32'd8, 32'h0);
        checks++;
        if (bus.rd !== 32'd0) begin
            errors++;
            $display("FAIL rst_priority addr=8: rd=%h expected=%h", bus.rd, 32'd0);
        end
        drive(1'b0, 1'b0, 32'd16, 32'h0);
        checks++;
        if (bus.rd !== 32'd0) begin
            errors++;
            $display("FAIL rst_clears addr=16: rd=%h expected=%h", bus.rd, 32'd0);
        end
    endtask

    task automatic test_read_during_write();
        drive(1'b0, 1'b1, 32'd20, 32'hA);
        drive(1'b0, 1'b1, 32'd20, 32'hB);
        checks++;
        if (bus.rd !== 32'hA) begin
            errors++;
            $display("FAIL rdw_before_edge: rd=%h expected=%h", bus.rd, 32'hA);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.rd !== 32'hB) begin
            errors++;
            $display("FAIL rdw_after_edge: rd=%h expected=%h", bus.rd, 32'hB);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] data  [3];
        addrs = '{32'd252, 32'd248, 32'd0};
        data  = '{32'hCAFE0001, 32'h0BADF00D, 32'h55AA55AA};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, addrs[i], data[i]);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, addrs[i], 32'h0);
            checks++;
            if (bus.rd !== data[i]) begin
                errors++;
                $display("FAIL back_to_back addr=%0d: rd=%h expected=%h", addrs[i], bus.rd, data[i]);
            end
        end
        drive(1'b0, 1'b0, 32'd20, 32'h0);
        checks++;
        if (bus.rd !== 32'hB) begin
            errors++;
            $display("FAIL back_to_back_keep addr=20: rd=%h expected=%h", bus.rd, 32'hB);
        end
    endtask

    initial begin
        rst          = 1'b0;
        bus.memwrite = 1'b0;
        bus.addr     = '0;
        bus.wd       = '0;
        test_reset();
        test_write_read();
        test_misaligned();
        test_out_of_range();
        test_reset_priority();
        test_read_during_write();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
